input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Front-end stage for the 14 raw board inputs (switches/buttons). Its debounced output bus drives the OR/LED combinational stage directly.
- Each bit is synchronised into `clk` and then filtered by its own stability counter.
- Also produces one-cycle rise/fall event pulses and a global settled flag, for later registered consumers.

Parameters:
- WIDTH, 14: number of input channels.
- SYNC_STAGES, 2: flops in each synchroniser chain. Must be ≥ 2.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised value must differ from the current output before the output takes it. Must be ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): width of each per-channel counter. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_raw  input  WIDTH  raw asynchronous pin levels.
- o_db  output  WIDTH  debounced levels; connects to the OR stage's `in` bus.
- o_rise  output  WIDTH  one-cycle pulse when o_db[n] goes 0→1.
- o_fall  output  WIDTH  one-cycle pulse when o_db[n] goes 1→0.
- o_any_change  output  1  OR of all o_rise and o_fall bits, registered together with them.
- o_settled  output  1  1 when every channel counter is 0 and every synchroniser output equals o_db.

Behaviour:
- Reset:
  - rst high asynchronously clears all synchroniser flops, counters, o_db, o_rise, o_fall and o_any_change to 0.
  - o_settled is 1 while in reset.
  - Reset release takes effect on the next rising edge.
- Synchroniser: chain of SYNC_STAGES flops per bit; sync[n] is the last stage. No logic between stages.
- Per-channel filter, evaluated every edge:
  - sync[n] == o_db[n]: cnt[n] ← 0.
  - sync[n] != o_db[n] and cnt[n] < DEBOUNCE_CYCLES-1: cnt[n] ← cnt[n]+1.
  - sync[n] != o_db[n] and cnt[n] == DEBOUNCE_CYCLES-1: o_db[n] ← sync[n] and cnt[n] ← 0. On that same edge, o_rise[n] ← sync[n] and o_fall[n] ← ~sync[n].
  - Every other edge: o_rise[n] and o_fall[n] ← 0.
- Latency: i_raw[n] changes and is then held stable, first sampled at edge 1. o_db[n] changes right after edge SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults). The rise/fall pulse is high for exactly the following cycle.
- Glitch rejection:
  - Any return of sync[n] to o_db[n] before the count completes restarts the count from 0.
  - A pulse of DEBOUNCE_CYCLES-1 synchronised cycles or fewer never reaches o_db.
- Channels are fully independent. Simultaneous transitions on several bits each produce their own pulses in the same cycle. o_any_change is 1 for that single cycle.
- o_rise[n] and o_fall[n] are never both 1.
- No edge pulse is generated at reset release; o_db starts at 0.
- Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count abandons the count. After release the channel requalifies from cnt = 0.
- o_settled is combinational from registered state (no extra latency).
- No latches. All outputs other than o_settled come directly from flops.

Test Plan:
- Reset: assert rst mid-run with i_raw = 14'h3FFF and several counters nonzero → all outputs 0 at once, o_settled = 1. Release → o_db stays 0 until a full qualification of 18 edges completes; no pulse at release.
- Clean rise (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): i_raw[0] 0→1 before edge 1 and held → o_db[0] = 1 after edge 6. o_rise[0] = 1 for exactly one cycle; o_any_change equals o_rise[0]; o_fall stays 0.
- Glitch (DEBOUNCE_CYCLES=4): i_raw[5] high for 3 cycles, then low → o_db[5] stays 0, no pulses, o_settled back to 1 within 3 edges of the drop. Repeat with 4 cycles high → o_db[5] rises.
- Bounce train: i_raw[13] toggles every 2 cycles for 20 cycles, then holds 1 → o_db[13] rises exactly once, 6 edges after the final hold; exactly one o_rise[13] pulse.
- Multi-channel: i_raw 14'h0000→14'h2AAA on one cycle, later →14'h1555 → first change gives o_rise = 14'h2AAA on a single cycle. Second change gives o_rise = 14'h1555 and o_fall = 14'h2AAA in the same cycle; o_any_change is a single pulse each time.
- Fall and reset mid-count: o_db[2] = 1, drop i_raw[2], assert rst after 2 counted cycles → o_db = 0, no o_fall pulse ever emitted for that event.

Source files
------------

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Front-end filter for raw board inputs (switches/buttons). Each channel is
// brought into the clk domain through its own flop chain and then filtered
// by its own stability counter. The debounced bus feeds the downstream
// combinational OR/LED stage directly. Registered rise/fall pulses and an
// aggregate change flag are also produced for later registered consumers.
//
// Parameters:
//   WIDTH            number of input channels
//   SYNC_STAGES      flops per synchroniser chain (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing cycles needed to accept a new level (>= 1)
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst           asynchronous active-high reset
//   i_raw         raw asynchronous pin levels
//   o_db          debounced levels (registered)
//   o_rise        one-cycle pulse per channel on a 0->1 debounced transition
//   o_fall        one-cycle pulse per channel on a 1->0 debounced transition
//   o_any_change  OR of all rise/fall pulses, registered alongside them
//   o_settled     every counter idle and every synchroniser output equals o_db
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int WIDTH           = 14,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_db,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_any_change,
    output logic             o_settled
);

    // Counter width is derived from the qualification length, never overridden.
    localparam int               CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic             cnt_idle;

    // Plain flop chain; nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= i_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Per-channel filter. Any agreement between sync and o_db restarts the
    // count, so only an unbroken run of DEBOUNCE_CYCLES differing samples
    // is accepted. The counter saturates by construction: at the terminal
    // count it either commits (and clears) or clears on agreement.
    always_comb begin
        db_d   = o_db;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < WIDTH; n++) begin
            cnt_d[n] = cnt_q[n];
            if (sync[n] == o_db[n]) begin
                cnt_d[n] = '0;
            end else if (cnt_q[n] == CNT_TC) begin
                cnt_d[n]  = '0;
                db_d[n]   = sync[n];
                rise_d[n] = sync[n];
                fall_d[n] = ~sync[n];
            end else begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < WIDTH; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_db         <= '0;
            o_rise       <= '0;
            o_fall       <= '0;
            o_any_change <= 1'b0;
        end else begin
            o_db         <= db_d;
            o_rise       <= rise_d;
            o_fall       <= fall_d;
            o_any_change <= |(rise_d | fall_d);
        end
    end

    // During reset all sources are cleared, so this naturally reads 1.
    always_comb begin
        cnt_idle = 1'b1;
        for (int n = 0; n < WIDTH; n++) begin
            if (cnt_q[n] != '0) begin
                cnt_idle = 1'b0;
            end
        end
    end

    assign o_settled = cnt_idle && (sync == o_db);

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

    localparam int W = 14;

    logic         clk;
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;
    logic         settled;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] rise_acc;
    logic [W-1:0] fall_acc;
    int           any_cnt;
    int           r13_cnt;
    logic         db5_seen;

    input_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_raw       (raw),
        .o_db        (db),
        .o_rise      (rise),
        .o_fall      (fall),
        .o_any_change(any_change),
        .o_settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if ((rise & fall) !== '0) begin
                n_fail++;
                $display("FAIL rise_fall_exclusive: rise=%h fall=%h required overlap 0", rise, fall);
            end
        end
    end

    task automatic clear_acc();
        rise_acc = '0;
        fall_acc = '0;
        any_cnt  = 0;
        r13_cnt  = 0;
        db5_seen = 1'b0;
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            rise_acc = rise_acc | rise;
            fall_acc = fall_acc | fall;
            any_cnt  = any_cnt + int'(any_change);
            r13_cnt  = r13_cnt + int'(rise[13]);
            db5_seen = db5_seen | db[5];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        raw = '0;
        #1;
        tick(2);
        rst = 1'b0;
        clear_acc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = '0;
        clear_acc();
        #3;
        n_checks++; if (db !== 14'h0000) begin n_fail++; $display("FAIL por_db: got %h want %h", db, 14'h0000); end
        n_checks++; if ((rise | fall) !== 14'h0000 || any_change !== 1'b0) begin n_fail++; $display("FAIL por_pulses: rise=%h fall=%h any=%b want all 0", rise, fall, any_change); end
        n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL por_settled: got %b want 1", settled); end
        tick(2);
        rst = 1'b0;
        tick(3);
        n_checks++; if (db !== 14'h0000 || settled !== 1'b1) begin n_fail++; $display("FAIL idle_after_release: db=%h settled=%b want 0000/1", db, settled); end

        raw = 14'h3FFF;
        tick(6);
        n_checks++; if (db !== 14'h3FFF || rise !== 14'h3FFF) begin n_fail++; $display("FAIL all_rise: db=%h rise=%h want 3fff/3fff", db, rise); end
        raw = 14'h0000;
        tick(4);
        n_checks++; if (db !== 14'h3FFF || settled !== 1'b0) begin n_fail++; $display("FAIL midcount: db=%h settled=%b want 3fff/0", db, settled); end

        raw = 14'h3FFF;
        rst = 1'b1;
        #1;
        n_checks++; if (db !== 14'h0000 || rise !== 14'h0000 || fall !== 14'h0000 || any_change !== 1'b0) begin n_fail++; $display("FAIL async_reset: db=%h rise=%h fall=%h any=%b want all 0", db, rise, fall, any_change); end
        n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL reset_settled: got %b want 1", settled); end
        tick(3);
        rst = 1'b0;
        clear_acc();
        tick(5);
        n_checks++; if (db !== 14'h0000) begin n_fail++; $display("FAIL requalify_early: db=%h want 0000 after 5 edges", db); end
        n_checks++; if (rise_acc !== 14'h0000 || fall_acc !== 14'h0000) begin n_fail++; $display("FAIL release_pulse: rise_acc=%h fall_acc=%h want 0", rise_acc, fall_acc); end
        tick(1);
        n_checks++; if (db !== 14'h3FFF || rise !== 14'h3FFF || any_change !== 1'b1) begin n_fail++; $display("FAIL requalify_done: db=%h rise=%h any=%b want 3fff/3fff/1", db, rise, any_change); end
    endtask

    task automatic test_clean_rise();
        do_reset();
        raw[0] = 1'b1;
        tick(5);
        n_checks++; if (db[0] !== 1'b0 || rise_acc !== 14'h0000) begin n_fail++; $display("FAIL rise_early: db0=%b rise_acc=%h want 0/0", db[0], rise_acc); end
        tick(1);
        n_checks++; if (db !== 14'h0001) begin n_fail++; $display("FAIL rise_db: got %h want 0001", db); end
        n_checks++; if (rise !== 14'h0001 || fall !== 14'h0000 || any_change !== 1'b1) begin n_fail++; $display("FAIL rise_pulse: rise=%h fall=%h any=%b want 0001/0000/1", rise, fall, any_change); end
        tick(1);
        n_checks++; if (rise !== 14'h0000 || any_change !== 1'b0 || db !== 14'h0001) begin n_fail++; $display("FAIL rise_one_cycle: rise=%h any=%b db=%h want 0000/0/0001", rise, any_change, db); end
        tick(4);
        n_checks++; if (any_cnt !== 1 || fall_acc !== 14'h0000 || settled !== 1'b1) begin n_fail++; $display("FAIL rise_tail: any_cnt=%0d fall_acc=%h settled=%b want 1/0000/1", any_cnt, fall_acc, settled); end
    endtask

    task automatic test_glitch();
        do_reset();
        raw[5] = 1'b1;
        tick(3);
        n_checks++; if (settled !== 1'b0) begin n_fail++; $display("FAIL glitch_counting: settled=%b want 0", settled); end
        raw[5] = 1'b0;
        tick(3);
        n_checks++; if (settled !== 1'b1) begin n_fail++; $display("FAIL glitch_resettle: settled=%b want 1", settled); end
        tick(4);
        n_checks++; if (db5_seen !== 1'b0 || rise_acc !== 14'h0000 || fall_acc !== 14'h0000 || any_cnt != 0) begin n_fail++; $display("FAIL glitch_rejected: db5_seen=%b rise_acc=%h fall_acc=%h any_cnt=%0d want 0", db5_seen, rise_acc, fall_acc, any_cnt); end

        clear_acc();
        raw[5] = 1'b1;
        tick(4);
        raw[5] = 1'b0;
        tick(1);
        n_checks++; if (db[5] !== 1'b0) begin n_fail++; $display("FAIL pulse4_early: db5=%b want 0", db[5]); end
        tick(1);
        n_checks++; if (db[5] !== 1'b1 || rise !== 14'h0020) begin n_fail++; $display("FAIL pulse4_pass: db5=%b rise=%h want 1/0020", db[5], rise); end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            raw[13] = 1'b1;
            tick(2);
            raw[13] = 1'b0;
            tick(2);
        end
        n_checks++; if (db[13] !== 1'b0 || r13_cnt != 0) begin n_fail++; $display("FAIL bounce_filtered: db13=%b rises=%0d want 0/0", db[13], r13_cnt); end
        raw[13] = 1'b1;
        tick(5);
        n_checks++; if (db[13] !== 1'b0) begin n_fail++; $display("FAIL bounce_early: db13=%b want 0 after 5 edges", db[13]); end
        tick(1);
        n_checks++; if (db[13] !== 1'b1) begin n_fail++; $display("FAIL bounce_hold: db13=%b want 1 after 6 edges", db[13]); end
        tick(6);
        n_checks++; if (r13_cnt != 1 || fall_acc !== 14'h0000) begin n_fail++; $display("FAIL bounce_single: rises=%0d fall_acc=%h want 1/0000", r13_cnt, fall_acc); end
    endtask

    task automatic test_multi();
        do_reset();
        raw = 14'h2AAA;
        tick(5);
        n_checks++; if (db !== 14'h0000 || rise_acc !== 14'h0000) begin n_fail++; $display("FAIL multi1_early: db=%h rise_acc=%h want 0", db, rise_acc); end
        tick(1);
        n_checks++; if (rise !== 14'h2AAA || fall !== 14'h0000 || any_change !== 1'b1 || db !== 14'h2AAA) begin n_fail++; $display("FAIL multi1: rise=%h fall=%h any=%b db=%h want 2aaa/0000/1/2aaa", rise, fall, any_change, db); end
        tick(3);
        n_checks++; if (any_cnt != 1 || rise !== 14'h0000) begin n_fail++; $display("FAIL multi1_single: any_cnt=%0d rise=%h want 1/0000", any_cnt, rise); end
        clear_acc();
        raw = 14'h1555;
        tick(6);
        n_checks++; if (rise !== 14'h1555 || fall !== 14'h2AAA || any_change !== 1'b1 || db !== 14'h1555) begin n_fail++; $display("FAIL multi2: rise=%h fall=%h any=%b db=%h want 1555/2aaa/1/1555", rise, fall, any_change, db); end
        tick(3);
        n_checks++; if (any_cnt != 1 || (rise | fall) !== 14'h0000 || settled !== 1'b1) begin n_fail++; $display("FAIL multi2_single: any_cnt=%0d rise|fall=%h settled=%b want 1/0000/1", any_cnt, rise | fall, settled); end
    endtask

    task automatic test_fall_reset();
        do_reset();
        raw[2] = 1'b1;
        tick(6);
        n_checks++; if (db !== 14'h0004) begin n_fail++; $display("FAIL fall_setup: db=%h want 0004", db); end
        tick(1);
        clear_acc();
        raw[2] = 1'b0;
        tick(4);
        n_checks++; if (db !== 14'h0004 || fall_acc !== 14'h0000) begin n_fail++; $display("FAIL fall_midcount: db=%h fall_acc=%h want 0004/0000", db, fall_acc); end
        rst = 1'b1;
        #1;
        n_checks++; if (db !== 14'h0000 || fall !== 14'h0000) begin n_fail++; $display("FAIL fall_reset: db=%h fall=%h want 0000/0000", db, fall); end
        tick(2);
        rst = 1'b0;
        tick(8);
        n_checks++; if (fall_acc !== 14'h0000 || rise_acc !== 14'h0000 || db !== 14'h0000) begin n_fail++; $display("FAIL fall_abandoned: fall_acc=%h rise_acc=%h db=%h want 0", fall_acc, rise_acc, db); end
    endtask

    initial begin
        rst = 1'b1;
        raw = '0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_bounce();
        test_multi();
        test_fall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
